// File: rtl/riscv_pkg.sv
// Shared types and constants for the 64-bit pipelined RISC-V core.
// Decode, ALU control and the ID/EX register all use idex_ctrl_t.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int RA_W = 5;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        aluop_e     alu_op;
        logic [2:0] funct3;
        logic       funct7_5;
    } idex_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Increment unless already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded control, operands, immediate and
// register addresses for execute. Supports stall (hold), flush (bubble) and a
// valid bit. Optional saturating stall/bubble counters under IDEX_PERF_CNT_EN.
module id_ex_reg #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int RA_W  = riscv_pkg::RA_W
`ifdef IDEX_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic            id_RegWrite,
    input  logic            id_MemtoReg,
    input  logic            id_MemRead,
    input  logic            id_MemWrite,
    input  logic            id_Branch,
    input  logic            id_ALUSrc,
    input  logic [1:0]      id_ALUOp,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    output logic            ex_RegWrite,
    output logic            ex_MemtoReg,
    output logic            ex_MemRead,
    output logic            ex_MemWrite,
    output logic            ex_Branch,
    output logic            ex_ALUSrc,
    output logic [1:0]      ex_ALUOp,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7_5,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_valid
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    import riscv_pkg::*;

    idex_ctrl_t      id_ctrl;
    idex_ctrl_t      ctrl_d,  ctrl_q;
    logic            valid_d, valid_q;
    logic [XLEN-1:0] pc_d,    pc_q;
    logic [XLEN-1:0] rd1_d,   rd1_q;
    logic [XLEN-1:0] rd2_d,   rd2_q;
    logic [XLEN-1:0] imm_d,   imm_q;
    logic [RA_W-1:0] rs1_d,   rs1_q;
    logic [RA_W-1:0] rs2_d,   rs2_q;
    logic [RA_W-1:0] rd_d,    rd_q;

    // Bundle the decoded control inputs; ALUOp 11 passes through untouched.
    always_comb begin
        id_ctrl            = '0;
        id_ctrl.reg_write  = id_RegWrite;
        id_ctrl.mem_to_reg = id_MemtoReg;
        id_ctrl.mem_read   = id_MemRead;
        id_ctrl.mem_write  = id_MemWrite;
        id_ctrl.branch     = id_Branch;
        id_ctrl.alu_src    = id_ALUSrc;
        id_ctrl.alu_op     = aluop_e'(id_ALUOp);
        id_ctrl.funct3     = id_funct3;
        id_ctrl.funct7_5   = id_funct7_5;
    end

    // Next contents: flush zeroes everything (beats stall), stall holds, else load.
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        if (flush) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            pc_d    = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
        end else if (!stall) begin
            ctrl_d  = id_ctrl;
            valid_d = id_valid;
            pc_d    = id_pc;
            rd1_d   = id_rd1;
            rd2_d   = id_rd2;
            imm_d   = id_imm;
            rs1_d   = id_rs1;
            rs2_d   = id_rs2;
            rd_d    = id_rd;
        end
    end

    // Pipeline register; reset overrides stall and flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
        end
    end

    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_MemtoReg = ctrl_q.mem_to_reg;
    assign ex_MemRead  = ctrl_q.mem_read;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_Branch   = ctrl_q.branch;
    assign ex_ALUSrc   = ctrl_q.alu_src;
    assign ex_ALUOp    = ctrl_q.alu_op;
    assign ex_funct3   = ctrl_q.funct3;
    assign ex_funct7_5 = ctrl_q.funct7_5;
    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rd1      = rd1_q;
    assign ex_rd2      = rd2_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;

`ifdef IDEX_PERF_CNT_EN
    logic bubble_inc;
    logic stall_inc;

    // A stall cycle only counts when it is not overridden by a flush.
    always_comb begin
        bubble_inc = flush;
        stall_inc  = stall & ~flush;
    end

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .count (bubble_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg with a queue-based scoreboard.
// Counter checks are active when built with IDEX_PERF_CNT_EN (counter width 4).
module tb_id_ex_reg;

    localparam int CW = 4;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        alu_src;
        logic [1:0]  alu_op;
        logic [2:0]  f3;
        logic        f75;
        logic [63:0] pc;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } vec_t;

    logic clk = 1'b0;
    logic reset, stall, flush;
    vec_t in_v;
    vec_t obs;
    vec_t exp_v;
    vec_t m_state;
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    logic [CW-1:0] bubble_count, stall_count;
    int            m_bubble, m_stall;

    always #5 clk = ~clk;

    id_ex_reg #(
        .XLEN(64), .RA_W(5)
`ifdef IDEX_PERF_CNT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .id_valid    (in_v.valid),
        .id_RegWrite (in_v.reg_write),
        .id_MemtoReg (in_v.mem_to_reg),
        .id_MemRead  (in_v.mem_read),
        .id_MemWrite (in_v.mem_write),
        .id_Branch   (in_v.branch),
        .id_ALUSrc   (in_v.alu_src),
        .id_ALUOp    (in_v.alu_op),
        .id_funct3   (in_v.f3),
        .id_funct7_5 (in_v.f75),
        .id_pc       (in_v.pc),
        .id_rd1      (in_v.rd1),
        .id_rd2      (in_v.rd2),
        .id_imm      (in_v.imm),
        .id_rs1      (in_v.rs1),
        .id_rs2      (in_v.rs2),
        .id_rd       (in_v.rd),
        .ex_RegWrite (obs.reg_write),
        .ex_MemtoReg (obs.mem_to_reg),
        .ex_MemRead  (obs.mem_read),
        .ex_MemWrite (obs.mem_write),
        .ex_Branch   (obs.branch),
        .ex_ALUSrc   (obs.alu_src),
        .ex_ALUOp    (obs.alu_op),
        .ex_funct3   (obs.f3),
        .ex_funct7_5 (obs.f75),
        .ex_pc       (obs.pc),
        .ex_rd1      (obs.rd1),
        .ex_rd2      (obs.rd2),
        .ex_imm      (obs.imm),
        .ex_rs1      (obs.rs1),
        .ex_rs2      (obs.rs2),
        .ex_rd       (obs.rd),
        .ex_valid    (obs.valid)
`ifdef IDEX_PERF_CNT_EN
        ,
        .bubble_count(bubble_count),
        .stall_count (stall_count)
`endif
    );

`ifndef IDEX_PERF_CNT_EN
    assign bubble_count = '0;
    assign stall_count  = '0;
`endif

    function automatic int sat_inc(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    // One clock: drive controls, update the reference model, queue the
    // expectation, then compare the DUT after the edge.
    task automatic step(input string tag, input logic rst, input logic st, input logic fl);
        reset = rst;
        stall = st;
        flush = fl;
        if (rst) begin
            m_state  = '0;
            m_bubble = 0;
            m_stall  = 0;
        end else if (fl) begin
            m_state  = '0;
            m_bubble = sat_inc(m_bubble);
        end else if (st) begin
            m_stall  = sat_inc(m_stall);
        end else begin
            m_state  = in_v;
        end
        exp_q.push_back(m_state);
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
`ifdef IDEX_PERF_CNT_EN
        tests++;
        assert (int'(bubble_count) === m_bubble) else begin
            fails++;
            $error("FAIL %s bubble_count: observed=%0d expected=%0d", tag, bubble_count, m_bubble);
        end
        tests++;
        assert (int'(stall_count) === m_stall) else begin
            fails++;
            $error("FAIL %s stall_count: observed=%0d expected=%0d", tag, stall_count, m_stall);
        end
`endif
    endtask

    // Invalid execute slot after reset/flush must not write anything.
    task automatic check_inv(input string tag);
        logic bad;
        bad = !obs.valid && (obs.reg_write || obs.mem_write || obs.mem_read);
        tests++;
        assert (bad === 1'b0) else begin
            fails++;
            $error("FAIL %s invariant: observed valid=%b rw=%b mw=%b mr=%b expected no writes",
                   tag, obs.valid, obs.reg_write, obs.mem_write, obs.mem_read);
        end
    endtask

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        in_v     = '0;
        m_state  = '0;
        m_bubble = 0;
        m_stall  = 0;
        #3;

        step("reset0", 1'b1, 1'b0, 1'b0);
        step("reset1", 1'b1, 1'b0, 1'b0);
        check_inv("reset");

        in_v = '0;
        in_v.valid = 1'b1; in_v.reg_write = 1'b1; in_v.alu_op = 2'b10;
        in_v.f3 = 3'b000;  in_v.f75 = 1'b1;
        in_v.rd1 = 64'h10; in_v.rd2 = 64'h3; in_v.rd = 5'd5;
        in_v.rs1 = 5'd6;   in_v.rs2 = 5'd7;  in_v.pc = 64'h40;
        step("load_sub", 1'b0, 1'b0, 1'b0);

        in_v.pc = 64'h100;
        step("load_pc100", 1'b0, 1'b0, 1'b0);
        in_v.pc = 64'h104;
        step("stall1", 1'b0, 1'b1, 1'b0);
        in_v.pc = 64'h108;
        step("stall2", 1'b0, 1'b1, 1'b0);
        in_v.pc = 64'h10C;
        step("stall3", 1'b0, 1'b1, 1'b0);
        step("release", 1'b0, 1'b0, 1'b0);

        in_v.reg_write = 1'b1; in_v.mem_write = 1'b1; in_v.rd = 5'd9;
        step("flush_stall", 1'b0, 1'b1, 1'b1);
        check_inv("flush_stall");

        in_v = '0;
        in_v.valid = 1'b0; in_v.reg_write = 1'b1; in_v.branch = 1'b1;
        in_v.rd1 = 64'hDEAD_BEEF_0000_1111; in_v.rd = 5'd3;
        step("invalid_passthru", 1'b0, 1'b0, 1'b0);

        in_v = '0;
        in_v.valid = 1'b1; in_v.alu_op = 2'b11; in_v.f3 = 3'b101;
        in_v.imm = 64'hFFFF_FFFF_FFFF_FFF0; in_v.rs1 = 5'd31;
        step("aluop11", 1'b0, 1'b0, 1'b0);

        in_v = '0;
        in_v.valid = 1'b1; in_v.reg_write = 1'b1; in_v.mem_to_reg = 1'b1;
        in_v.mem_read = 1'b1; in_v.alu_src = 1'b1; in_v.f3 = 3'b011;
        in_v.imm = 64'h8; in_v.rs1 = 5'd2; in_v.rd = 5'd10; in_v.pc = 64'h200;
        step("load_ld", 1'b0, 1'b0, 1'b0);
        in_v.pc = 64'h204;
        step("ld_stall1", 1'b0, 1'b1, 1'b0);
        step("ld_stall2", 1'b0, 1'b1, 1'b0);
        step("reset_mid_stall", 1'b1, 1'b1, 1'b0);
        check_inv("reset_mid_stall");

        in_v.pc = 64'h300;
        step("reload", 1'b0, 1'b0, 1'b0);
        step("reset_over_flush", 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            in_v.valid = 1'($urandom);
            in_v.reg_write = 1'($urandom); in_v.mem_to_reg = 1'($urandom);
            in_v.mem_read = 1'($urandom);  in_v.mem_write = 1'($urandom);
            in_v.branch = 1'($urandom);    in_v.alu_src = 1'($urandom);
            in_v.alu_op = 2'($urandom);    in_v.f3 = 3'($urandom);
            in_v.f75 = 1'($urandom);
            in_v.pc = {$urandom, $urandom};  in_v.rd1 = {$urandom, $urandom};
            in_v.rd2 = {$urandom, $urandom}; in_v.imm = {$urandom, $urandom};
            in_v.rs1 = 5'($urandom); in_v.rs2 = 5'($urandom); in_v.rd = 5'($urandom);
            step("random", 1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end

        step("reset_pre_sat", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("flush_sat", 1'b0, 1'b0, 1'b1);
        end
        check_inv("flush_sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
